// File: rtl/pulse_window_counter_pkg.sv
// Shared types and helpers for the gated pulse/coincidence counter.
// Holds the state encoding, the saturating increment and the gate-counter width helper.
package pulse_window_counter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int DEFAULT_GATE_CYCLES = 1000000;
    localparam int SAT_W = 64;

    // Gate counter spans 0..cycles-1, so clog2(cycles) bits suffice; never below one bit.
    function automatic int gate_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // Adds inc to value but sticks at the all-ones value of a width-bit counter.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int width,
                                                 input logic inc);
        logic [SAT_W-1:0] top;
        top = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        if (inc && (value < top))
            return value + SAT_W'(1);
        return value;
    endfunction

endpackage

// File: rtl/pulse_window_counter_stretch.sv
// Single-channel retriggerable pulse stretcher; built only with PULSE_WINDOW_COINC_STRETCH_EN.
// Output is high on the pulse cycle and the following STRETCH-1 cycles.
`ifdef PULSE_WINDOW_COINC_STRETCH_EN
module pulse_stretch #(
    parameter int STRETCH = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic pulse,
    output logic stretched
);

    logic [3:0] remain;

    always_ff @(posedge clock) begin
        if (!reset_n || clear)
            remain <= 4'd0;
        else if (pulse)
            remain <= 4'(STRETCH - 1);
        else if (remain != 4'd0)
            remain <= remain - 4'd1;
    end

    assign stretched = pulse | (remain != 4'd0);

endmodule
`endif

// File: rtl/pulse_window_counter.sv
// Counts per-channel singles and masked coincidences over back-to-back gate windows,
// handing a snapshot out over valid/ready. Macro PULSE_WINDOW_COINC_STRETCH_EN enables stretched coincidences.
module pulse_window_counter
    import pulse_window_counter_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int WIDTH         = 24,
    parameter int GATE_CYCLES   = DEFAULT_GATE_CYCLES,
    parameter int COINC_STRETCH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [NCH-1:0]         pulse,
    input  logic [NCH-1:0]         coinc_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*WIDTH-1:0]   singles,
    output logic [WIDTH-1:0]       coinc,
    output logic                   overrun,
    output logic                   busy
);

    localparam int GW = gate_width(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    if (NCH < 1 || NCH > 8 || GATE_CYCLES < 2 || COINC_STRETCH < 1 || COINC_STRETCH > 15) begin : g_bad_param
        $error("pulse_window_counter: parameter out of range");
    end

    state_t               state;
    logic [GW-1:0]        gate_cnt;
    logic [NCH*WIDTH-1:0] acc;
    logic [NCH*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]     acc_c;
    logic [WIDTH-1:0]     acc_c_next;
    logic [NCH-1:0]       mask_q;
    logic                 coinc_hit;
    logic                 terminal;
    logic                 xfer;

`ifdef PULSE_WINDOW_COINC_STRETCH_EN
    logic [NCH-1:0] stretched;
    logic           and_now;
    logic           and_prev;

    for (genvar g = 0; g < NCH; g++) begin : g_stretch
        pulse_stretch #(.STRETCH(COINC_STRETCH)) u_stretch (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (state == ST_IDLE),
            .pulse     (pulse[g]),
            .stretched (stretched[g])
        );
    end

    // Count only the rising edge so one overlapping burst is one coincidence.
    assign and_now   = (mask_q != '0) && ((stretched & mask_q) == mask_q);
    assign coinc_hit = and_now & ~and_prev;

    always_ff @(posedge clock) begin
        if (!reset_n || state == ST_IDLE)
            and_prev <= 1'b0;
        else
            and_prev <= and_now;
    end
`else
    assign coinc_hit = (mask_q != '0) && ((pulse & mask_q) == mask_q);
`endif

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < NCH; i++)
            acc_next[i*WIDTH +: WIDTH] = WIDTH'(sat_inc(64'(acc[i*WIDTH +: WIDTH]), WIDTH, pulse[i]));
    end

    assign acc_c_next = WIDTH'(sat_inc(64'(acc_c), WIDTH, coinc_hit));
    assign terminal   = (gate_cnt == GATE_LAST);
    assign xfer       = out_valid & out_ready;
    assign busy       = (state == ST_COUNT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            gate_cnt  <= '0;
            acc       <= '0;
            acc_c     <= '0;
            mask_q    <= '0;
            out_valid <= 1'b0;
            singles   <= '0;
            coinc     <= '0;
            overrun   <= 1'b0;
        end else begin
            // A snapshot loaded on the same edge below overrides this drop.
            if (xfer)
                out_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_COUNT;
                        gate_cnt <= '0;
                        acc      <= '0;
                        acc_c    <= '0;
                        mask_q   <= coinc_mask;
                        overrun  <= 1'b0;
                    end
                end

                ST_COUNT: begin
                    if (terminal) begin
                        if (out_valid && !out_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            singles   <= acc_next;
                            coinc     <= acc_c_next;
                            out_valid <= 1'b1;
                        end
                        gate_cnt <= '0;
                        acc      <= '0;
                        acc_c    <= '0;
                        mask_q   <= coinc_mask;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        acc      <= acc_next;
                        acc_c    <= acc_c_next;
                    end
                    // Mid-window fall drops the partial counts; terminal fall still issues the snapshot.
                    if (!enable)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_window_counter.sv
// Bench for pulse_window_counter: directed window scenarios plus random traffic,
// checked every cycle against a window-level behavioural model.
module tb_pulse_window_counter;

    localparam int NCH     = 4;
    localparam int WIDTH   = 4;
    localparam int GATE    = 20;
    localparam int STRETCH = 2;
    localparam int MAXV    = (1 << WIDTH) - 1;
    localparam int SW      = (NCH + 1) * WIDTH;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic [NCH-1:0]       pulse = '0;
    logic [NCH-1:0]       coinc_mask = '0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [NCH*WIDTH-1:0] singles;
    logic [WIDTH-1:0]     coinc;
    logic                 overrun;
    logic                 busy;

    pulse_window_counter #(
        .NCH(NCH), .WIDTH(WIDTH), .GATE_CYCLES(GATE), .COINC_STRETCH(STRETCH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .pulse(pulse),
        .coinc_mask(coinc_mask), .out_valid(out_valid), .out_ready(out_ready),
        .singles(singles), .coinc(coinc), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_run = 0;
    int             m_pos = 0;
    int             m_cnt[NCH];
    int             m_cc = 0;
    logic [NCH-1:0] m_mask = '0;
    bit             m_valid = 0;
    bit             m_ovr = 0;
    int             m_cyc = 0;
    int             m_last[NCH];
    bit             m_prev = 0;
    logic [SW-1:0]  exp_q[$];

    function automatic logic [SW-1:0] model_snap();
        logic [SW-1:0] r;
        r = '0;
        r[NCH*WIDTH +: WIDTH] = WIDTH'(m_cc);
        for (int i = 0; i < NCH; i++)
            r[i*WIDTH +: WIDTH] = WIDTH'(m_cnt[i]);
        return r;
    endfunction

    function automatic void model_clear_window();
        for (int i = 0; i < NCH; i++)
            m_cnt[i] = 0;
        m_cc  = 0;
        m_pos = 0;
    endfunction

    always @(posedge clock) begin
        bit accepted;
        bit hit;
        bit and_now;
        logic [NCH-1:0] str;
        m_cyc++;
        if (!reset_n) begin
            m_run = 0; m_valid = 0; m_ovr = 0; m_mask = '0;
            model_clear_window();
            exp_q.delete();
        end else begin
            accepted = m_valid && out_ready;
            if (!m_run) begin
                if (accepted) begin
                    void'(exp_q.pop_front());
                    m_valid = 0;
                end
                if (enable) begin
                    m_run = 1; m_ovr = 0; m_mask = coinc_mask; m_prev = 0;
                    model_clear_window();
                    for (int i = 0; i < NCH; i++)
                        m_last[i] = -1000;
                end
            end else begin
                for (int i = 0; i < NCH; i++)
                    if (pulse[i]) m_cnt[i] = (m_cnt[i] + 1 > MAXV) ? MAXV : m_cnt[i] + 1;
`ifdef PULSE_WINDOW_COINC_STRETCH_EN
                for (int i = 0; i < NCH; i++) begin
                    if (pulse[i]) m_last[i] = m_cyc;
                    str[i] = ((m_cyc - m_last[i]) < STRETCH);
                end
                and_now = (m_mask != '0) && ((str & m_mask) == m_mask);
                hit     = and_now && !m_prev;
                m_prev  = and_now;
`else
                str = '0;
                and_now = 0;
                hit = (m_mask != '0) && ((pulse & m_mask) == m_mask);
`endif
                if (hit) m_cc = (m_cc + 1 > MAXV) ? MAXV : m_cc + 1;
                if (m_pos == GATE - 1) begin
                    if (m_valid && !out_ready) begin
                        m_ovr = 1;
                    end else begin
                        if (accepted) void'(exp_q.pop_front());
                        exp_q.push_back(model_snap());
                        m_valid = 1;
                    end
                    model_clear_window();
                    m_mask = coinc_mask;
                end else begin
                    if (accepted) begin
                        void'(exp_q.pop_front());
                        m_valid = 0;
                    end
                    m_pos++;
                end
                if (!enable) m_run = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_run));
        check("overrun", 64'(overrun), 64'(m_ovr));
        if (m_valid) begin
            if (exp_q.size() == 0)
                check("exp_q_empty", 64'(1), 64'(0));
            else
                check("snapshot", 64'({coinc, singles}), 64'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    logic [NCH-1:0] wpat[GATE];

    task automatic clear_pat();
        for (int i = 0; i < GATE; i++)
            wpat[i] = '0;
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            @(negedge clock);
            pulse = wpat[i];
        end
    endtask

    task automatic expect_snap(input string name, input int e0, input int e1, input int e2,
                               input int e3, input int ec, input int eo);
        @(posedge clock);
        #1;
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_ch0"}, 64'(singles[0*WIDTH +: WIDTH]), 64'(e0));
        check({name, "_ch1"}, 64'(singles[1*WIDTH +: WIDTH]), 64'(e1));
        check({name, "_ch2"}, 64'(singles[2*WIDTH +: WIDTH]), 64'(e2));
        check({name, "_ch3"}, 64'(singles[3*WIDTH +: WIDTH]), 64'(e3));
        check({name, "_coinc"}, 64'(coinc), 64'(ec));
        check({name, "_overrun"}, 64'(overrun), 64'(eo));
    endtask

    initial begin
        int stretch_coinc;
`ifdef PULSE_WINDOW_COINC_STRETCH_EN
        stretch_coinc = 1;
`else
        stretch_coinc = 0;
`endif
        // Clock/reset
        repeat (3) @(negedge clock);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_singles", 64'(singles), 64'(0));
        check("rst_coinc", 64'(coinc), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset_n = 1'b1; out_ready = 1'b1; coinc_mask = 4'b0011; enable = 1'b1;

        // W1: singles only, no simultaneous masked pair
        clear_pat();
        wpat[2] = 4'b0001; wpat[5] = 4'b0001; wpat[9] = 4'b0001; wpat[7] = 4'b0010;
        play(0, GATE - 1);
        expect_snap("w1", 3, 1, 0, 0, 0, 0);

        // W2: mask 0011, two pairs plus one lone ch0
        clear_pat();
        wpat[1] = 4'b0011; wpat[4] = 4'b0011; wpat[8] = 4'b0001;
        play(0, GATE - 1);
        coinc_mask = 4'b0000;
        expect_snap("w2", 3, 2, 0, 0, 2, 0);

        // W3: same pattern, mask 0
        play(0, GATE - 1);
        expect_snap("w3", 3, 2, 0, 0, 0, 0);

        // W4: ch2 every cycle saturates; ch0 on the terminal cycle
        for (int i = 0; i < GATE; i++) wpat[i] = 4'b0100;
        wpat[GATE-1] = 4'b0101;
        play(0, GATE - 1);
        expect_snap("w4", 1, 0, 15, 0, 0, 0);

        // W5: ch0 on the first cycle; its snapshot is then held under backpressure
        clear_pat();
        wpat[0] = 4'b0001;
        play(0, GATE - 1);
        out_ready = 1'b0;
        expect_snap("w5", 1, 0, 0, 0, 0, 0);

        // W6: random contents, discarded
        for (int i = 0; i < GATE; i++) wpat[i] = NCH'($urandom);
        play(0, GATE - 1);
        expect_snap("w6_held", 1, 0, 0, 0, 0, 1);

        // W7: release mid-window; out_valid must fall with nothing due
        clear_pat();
        wpat[2] = 4'b1000;
        play(0, 2);
        out_ready = 1'b1;
        play(3, 4);
        check("w7_xfer_fell", 64'(out_valid), 64'(0));
        play(5, GATE - 1);
        expect_snap("w7", 0, 0, 0, 1, 0, 1);

        // W8: abort at gate cycle 5
        clear_pat();
        wpat[1] = 4'b1000;
        play(0, 4);
        @(negedge clock);
        enable = 1'b0; pulse = '0;
        repeat (GATE + 3) @(negedge clock);
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_overrun_sticky", 64'(overrun), 64'(1));

        // W9: restart; ch0/ch1 one cycle apart, two ch3 pulses
        coinc_mask = 4'b0011; enable = 1'b1;
        clear_pat();
        wpat[3] = 4'b0001; wpat[4] = 4'b0010; wpat[10] = 4'b1000; wpat[15] = 4'b1000;
        play(0, GATE - 1);
        expect_snap("w9", 1, 1, 0, 2, stretch_coinc, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            pulse = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : NCH'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) coinc_mask = NCH'($urandom);
            reset_n = ($urandom_range(0, 999) != 0);
        end
        @(negedge clock);
        reset_n = 1'b1; pulse = '0;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
